mem_port2_arbiter: RTL and testbench
====================================

Name: mem_port2_arbiter

Overview:
Arbitrates two requesters onto read/write port 2 of MEMORY: requester 0 is the pipeline memory stage, requester 1 is the loader/debug unit. Owns the port-2 write enable, address, and tri-state data bus. Each requester uses a req/ack handshake with latched read data. Fixed priority goes to requester 0, with a starvation limit that guarantees requester 1 progress.

Parameters:
NUM_BYTES, 64, memory size in bytes; an address at or above this value is out of range.
STARVE_LIMIT, 4, number of consecutive requester-0 grants while req1 is pending before requester 1 is forced a grant (range 1..15).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request; held with we0/addr0/wdata0 stable until ack0
we0  input  1  requester 0 write (1) / read (0)
addr0  input  32  requester 0 byte address, word aligned
wdata0  input  32  requester 0 write data
ack0  output  1  one-cycle completion pulse for requester 0
err0  output  1  valid with ack0; access rejected
rdata0  output  32  requester 0 read data, valid with ack0
req1, we1, addr1, wdata1, ack1, err1, rdata1  same as the requester 0 ports, for requester 1
mem_write_enable2  output  1  to MEMORY memory_write_enable2
mem_address2  output  32  to MEMORY memory_address2
mem_data2  inout  32  to MEMORY memory_data2; driven only while writing, otherwise Z
busy  output  1  high while state is not IDLE

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - state IDLE
  - ack*/err* 0, rdata* 0
  - mem_write_enable2 0, mem_address2 0, mem_data2 Z
  - starve counter 0, busy 0
- MEMORY timing: port-2 read data is combinational from the address. A write commits at the rising edge while mem_write_enable2=1.
- FSM transitions: IDLE -> ACCESS -> RESP -> IDLE. Every access has the same latency.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose the winner, latch id/we/addr/wdata/err_flag, go to ACCESS.
  - err_flag = (addr[1:0] != 0) or (addr >= NUM_BYTES).
- ACCESS:
  - mem_address2 = latched addr.
  - mem_write_enable2 = we & ~err_flag.
  - mem_data2 = latched wdata when writing, else Z.
  - At the closing edge: the write commits, or mem_data2 is captured into the winner's rdata. Capture 0 if err_flag.
  - Next state: RESP.
- RESP:
  - Winner's ack = 1 for exactly one cycle; err = err_flag. The other requester sees ack=0.
  - Bus returns to Z with enable 0.
  - Next state: IDLE.
- Latency: request sampled at edge E0, ack high in the cycle after E1, state back to IDLE at E2. Peak rate is one access per 3 cycles.
- Requester rules:
  - Drop req on the edge that ends the ack cycle.
  - If req is still high when IDLE is re-entered, it is a new request.
  - A change in req or fields between E0 and ack is ignored, because fields are latched.
- Arbitration, evaluated only in IDLE:
  - Only one req high: grant that requester.
  - Both high: grant 1 if counter == STARVE_LIMIT, else grant 0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when 0 is granted while req1=1.
  - Clears when 1 is granted, or when 0 is granted with req1=0.
- rdata of the non-winning requester holds its previous value.
- Error accesses never assert mem_write_enable2, and memory contents are unchanged.
- Reset mid-operation:
  - Asynchronous return to IDLE; the enable drops immediately and the bus goes Z.
  - A write whose commit edge has not occurred does not commit.
  - No ack is issued for the aborted access.
- Memory image for tests: word at byte address 4k = {k[15:0], k[15:0]}.

Test Plan:
1. Hold rst_n=0 with random req inputs -> ack0/ack1/err*/busy=0, mem_write_enable2=0, mem_data2=Z, rdata*=0. Release -> IDLE.
2. req1 read addr 8 -> busy high for 2 cycles; ack1 pulses in the cycle after E1 with rdata1=0x00020002, err1=0. Read addr 4 -> 0x00010001.
3. req0 write 0x01234567 to addr 4. Then req1 read 4 -> 0x01234567; read 8 -> 0x00020002; read 0 -> 0x00000000.
4. STARVE_LIMIT=2, req0 and req1 held high continuously (re-requesting after each ack) -> grant sequence 0,0,1,0,0,1. ack1 never starves beyond 2 consecutive requester-0 grants.
5. req0 write addr 6, then req1 read addr 64 (NUM_BYTES=64):
   - Each gets an ack with err=1 and rdata=0.
   - mem_write_enable2 is never asserted.
   - Subsequent read of 4 is unchanged.
6. req0 write 0xDEADBEEF to addr 8; assert rst_n=0 during ACCESS before its closing edge -> no ack0, enable drops immediately. After release, read 8 returns 0x00020002.

Source files
------------

// File: rtl/mem_port2_arbiter.sv
// Two-requester arbiter for read/write port 2 of MEMORY.
// Requester 0 (pipeline memory stage) has fixed priority. Requester 1 (loader/debug)
// is guaranteed a grant after STARVE_LIMIT consecutive requester-0 grants while it waits.
// Each access runs IDLE -> ACCESS -> RESP -> IDLE, so every access has the same latency.
module mem_port2_arbiter #(
    parameter int unsigned NUM_BYTES    = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,

    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,

    output logic        mem_write_enable2,
    output logic [31:0] mem_address2,
    inout  wire  [31:0] mem_data2,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e      state_q, state_d;

    // Latched access, captured when the grant is made in IDLE.
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [3:0]  starve_q, starve_d;

    // Registered outputs.
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        wen_q, wen_d;
    logic [31:0] maddr_q, maddr_d;

    // Arbitration result and the winner's request fields.
    logic        grant1;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        starved;

    // Fixed priority to requester 0 unless requester 1 has waited out the starve limit.
    always_comb begin
        starved   = (starve_q == 4'(STARVE_LIMIT));
        grant1    = req1 & (~req0 | starved);
        sel_we    = grant1 ? we1    : we0;
        sel_addr  = grant1 ? addr1  : addr0;
        sel_wdata = grant1 ? wdata1 : wdata0;
        // Misaligned or out-of-range accesses complete with an error and touch nothing.
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= 32'(NUM_BYTES));
    end

    // Next-state logic for the access sequencer, starve counter and registered outputs.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        wen_d    = 1'b0;
        maddr_d  = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StAccess;
                    id_d    = grant1;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = sel_err;
                    // Drive the port for the whole ACCESS cycle.
                    wen_d   = sel_we & ~sel_err;
                    maddr_d = sel_addr;

                    if (grant1) begin
                        starve_d = 4'd0;
                    end else if (req1) begin
                        if (!starved) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        starve_d = 4'd0;
                    end
                end
            end

            StAccess: begin
                state_d = StResp;
                // Writes commit in memory at this edge; reads sample the bus here.
                if (err_q) begin
                    if (id_q) begin
                        rdata1_d = 32'd0;
                    end else begin
                        rdata0_d = 32'd0;
                    end
                end else if (!we_q) begin
                    if (id_q) begin
                        rdata1_d = mem_data2;
                    end else begin
                        rdata0_d = mem_data2;
                    end
                end
                ack0_d = ~id_q;
                ack1_d = id_q;
                err0_d = ~id_q & err_q;
                err1_d = id_q & err_q;
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any access without an ack or a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            starve_q <= 4'd0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
            wen_q    <= 1'b0;
            maddr_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            wen_q    <= wen_d;
            maddr_q  <= maddr_d;
        end
    end

    assign ack0              = ack0_q;
    assign ack1              = ack1_q;
    assign err0              = err0_q;
    assign err1              = err1_q;
    assign rdata0            = rdata0_q;
    assign rdata1            = rdata1_q;
    assign mem_write_enable2 = wen_q;
    assign mem_address2      = maddr_q;
    assign busy              = (state_q != StIdle);

    // The bus is only driven while a write is in progress.
    assign mem_data2 = wen_q ? wdata_q : 32'bz;

    // Only one requester is ever acknowledged in a cycle.
    a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n) !(ack0 && ack1));

    // An erroring access never writes memory.
    a_no_err_write : assert property (@(posedge clk) disable iff (!rst_n)
        mem_write_enable2 |-> !err_q);

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Randomized self-checking bench for mem_port2_arbiter with a transaction-level model.
module tb_mem_port2_arbiter;

    localparam int unsigned NB = 64;
    localparam int unsigned SL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0, we0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        mem_write_enable2, busy;
    logic [31:0] mem_address2;
    wire  [31:0] mem_data2;

    // Requester-side drive values.
    logic        r_req [2];
    logic        r_we [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];

    assign req0 = r_req[0];
    assign we0 = r_we[0];
    assign addr0 = r_addr[0];
    assign wdata0 = r_wdata[0];
    assign req1 = r_req[1];
    assign we1 = r_we[1];
    assign addr1 = r_addr[1];
    assign wdata1 = r_wdata[1];

    mem_port2_arbiter #(
        .NUM_BYTES    (NB),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req0              (req0),
        .we0               (we0),
        .addr0             (addr0),
        .wdata0            (wdata0),
        .ack0              (ack0),
        .err0              (err0),
        .rdata0            (rdata0),
        .req1              (req1),
        .we1               (we1),
        .addr1             (addr1),
        .wdata1            (wdata1),
        .ack1              (ack1),
        .err1              (err1),
        .rdata1            (rdata1),
        .mem_write_enable2 (mem_write_enable2),
        .mem_address2      (mem_address2),
        .mem_data2         (mem_data2),
        .busy              (busy)
    );

    // MEMORY port 2: combinational read, write at the rising edge.
    logic        mem_init;
    logic [31:0] mem [16];
    logic [31:0] mem_rd;
    always_comb mem_rd = (mem_address2 < 32'(NB)) ? mem[mem_address2[5:2]] : 32'd0;
    assign mem_data2 = mem_write_enable2 ? 32'bz : mem_rd;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 16; k++) mem[k] <= {16'(k), 16'(k)};
        end else if (mem_write_enable2) begin
            mem[mem_address2[5:2]] <= mem_data2;
        end
    end

    int n_total = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = access in flight, 2 = response cycle.
    int          m_phase;
    int          m_win;
    int          m_cnt;
    logic        m_we, m_err;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_mem [16];
    logic [31:0] m_rdata [2];

    task automatic mdl_reset();
        m_phase = 0;
        m_win = 0;
        m_cnt = 0;
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;
    endtask

    // Apply the effect of the coming rising edge given the currently driven requests.
    task automatic mdl_edge();
        if (m_phase == 0) begin
            if (r_req[0] || r_req[1]) begin
                int w;
                if (r_req[0] && r_req[1]) w = (m_cnt == SL) ? 1 : 0;
                else w = r_req[1] ? 1 : 0;
                if (w == 1) m_cnt = 0;
                else if (r_req[1]) m_cnt = (m_cnt < SL) ? m_cnt + 1 : SL;
                else m_cnt = 0;
                m_win = w;
                m_we = r_we[w];
                m_addr = r_addr[w];
                m_wdata = r_wdata[w];
                m_err = (m_addr % 4 != 0) || (m_addr >= NB);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_err) m_rdata[m_win] = 32'd0;
            else if (m_we) m_mem[m_addr / 4] = m_wdata;
            else m_rdata[m_win] = m_mem[m_addr / 4];
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_cycle();
        logic resp0, resp1;
        resp0 = (m_phase == 2) && (m_win == 0);
        resp1 = (m_phase == 2) && (m_win == 1);
        check_eq("ack0", 32'(ack0), 32'(resp0));
        check_eq("ack1", 32'(ack1), 32'(resp1));
        check_eq("err0", 32'(err0), 32'(resp0 && m_err));
        check_eq("err1", 32'(err1), 32'(resp1 && m_err));
        check_eq("rdata0", rdata0, m_rdata[0]);
        check_eq("rdata1", rdata1, m_rdata[1]);
        check_eq("busy", 32'(busy), 32'(m_phase != 0));
        check_eq("wen", 32'(mem_write_enable2), 32'(m_phase == 1 && m_we && !m_err));
        if (m_phase == 1) check_eq("maddr", mem_address2, m_addr);
    endtask

    task automatic step();
        mdl_edge();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    // One complete access from requester k; returns the DUT's response.
    task automatic do_op(input int k, input logic we, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic e);
        logic got;
        got = 1'b0;
        r_req[k] = 1'b1;
        r_we[k] = we;
        r_addr[k] = a;
        r_wdata[k] = d;
        for (int i = 0; i < 20; i++) begin
            step();
            got = (k == 0) ? ack0 : ack1;
            if (got) break;
        end
        if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
        rd = (k == 0) ? rdata0 : rdata1;
        e = (k == 0) ? err0 : err1;
        r_req[k] = 1'b0;
        step();
    endtask

    task automatic new_op(input int k);
        int sel;
        sel = $urandom_range(0, 7);
        r_req[k] = 1'b1;
        r_we[k] = 1'($urandom_range(0, 1));
        r_wdata[k] = $urandom;
        if (sel == 0) r_addr[k] = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (sel == 1) r_addr[k] = 32'($urandom_range(16, 40) * 4);
        else r_addr[k] = 32'($urandom_range(0, 15) * 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          dut_log[$];
        int          exp_seq[6];
        logic        a0, a1;

        exp_seq = '{0, 0, 1, 0, 0, 1};

        // Reset held with random request activity.
        mem_init = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0;
            r_we[i] = 1'b0;
            r_addr[i] = 32'd0;
            r_wdata[i] = 32'd0;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            new_op(0);
            new_op(1);
            #1;
            check_eq("rst_ack0", 32'(ack0), 32'd0);
            check_eq("rst_ack1", 32'(ack1), 32'd0);
            check_eq("rst_err", 32'({err0, err1}), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_wen", 32'(mem_write_enable2), 32'd0);
            check_eq("rst_rdata0", rdata0, 32'd0);
            check_eq("rst_rdata1", rdata1, 32'd0);
        end
        @(negedge clk);
        mem_init = 1'b0;
        for (int k = 0; k < 16; k++) m_mem[k] = {16'(k), 16'(k)};
        mdl_reset();
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        rst_n = 1'b1;
        step();

        // Basic reads from requester 1.
        do_op(1, 1'b0, 32'd8, 32'd0, rd, e);
        check_eq("rd8", rd, 32'h0002_0002);
        check_eq("rd8_err", 32'(e), 32'd0);
        do_op(1, 1'b0, 32'd4, 32'd0, rd, e);
        check_eq("rd4", rd, 32'h0001_0001);

        // Write from requester 0, read back from requester 1.
        do_op(0, 1'b1, 32'd4, 32'h0123_4567, rd, e);
        check_eq("wr4_err", 32'(e), 32'd0);
        do_op(1, 1'b0, 32'd4, 32'd0, rd, e);
        check_eq("rd4_after_wr", rd, 32'h0123_4567);
        do_op(1, 1'b0, 32'd8, 32'd0, rd, e);
        check_eq("rd8_after_wr", rd, 32'h0002_0002);
        do_op(1, 1'b0, 32'd0, 32'd0, rd, e);
        check_eq("rd0", rd, 32'h0000_0000);

        // Both requesters held continuously: starvation limit forces every third grant to 1.
        r_req[0] = 1'b1;
        r_we[0] = 1'b0;
        r_addr[0] = 32'd12;
        r_req[1] = 1'b1;
        r_we[1] = 1'b0;
        r_addr[1] = 32'd16;
        for (int c = 0; c < 40 && dut_log.size() < 6; c++) begin
            step();
            if (ack0) dut_log.push_back(0);
            if (ack1) dut_log.push_back(1);
        end
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("grant_seq%0d", i),
                     32'((i < dut_log.size()) ? dut_log[i] : 99), 32'(exp_seq[i]));
        end
        step();
        step();

        // Error accesses: misaligned write, out-of-range read.
        do_op(0, 1'b1, 32'd6, 32'hFFFF_FFFF, rd, e);
        check_eq("err_wr6", 32'(e), 32'd1);
        check_eq("err_wr6_rdata", rd, 32'd0);
        do_op(1, 1'b0, 32'd64, 32'd0, rd, e);
        check_eq("err_rd64", 32'(e), 32'd1);
        check_eq("err_rd64_rdata", rd, 32'd0);
        do_op(1, 1'b0, 32'd4, 32'd0, rd, e);
        check_eq("rd4_after_err", rd, 32'h0123_4567);

        // Reset during the ACCESS cycle of a write aborts it.
        r_req[0] = 1'b1;
        r_we[0] = 1'b1;
        r_addr[0] = 32'd8;
        r_wdata[0] = 32'hDEAD_BEEF;
        step();
        check_eq("abort_in_access", 32'(mem_write_enable2), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_wen", 32'(mem_write_enable2), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        r_req[0] = 1'b0;
        mdl_reset();
        a0 = 1'b0;
        a1 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            a0 = a0 | ack0;
            a1 = a1 | ack1;
        end
        check_eq("abort_no_ack", 32'({a0, a1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_op(1, 1'b0, 32'd8, 32'd0, rd, e);
        check_eq("rd8_after_abort", rd, 32'h0002_0002);

        // Random traffic from both requesters.
        for (int c = 0; c < 800; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                logic acked;
                acked = (k == 0) ? ack0 : ack1;
                if (acked) begin
                    if ($urandom_range(0, 1) == 1) new_op(k);
                    else r_req[k] = 1'b0;
                end else if (!r_req[k]) begin
                    if ($urandom_range(0, 2) == 0) new_op(k);
                end else if (m_phase == 1 && m_win == k && $urandom_range(0, 1) == 1) begin
                    // Changes after the grant must be ignored.
                    r_we[k] = ~r_we[k];
                    r_addr[k] = $urandom;
                    r_wdata[k] = $urandom;
                end
            end
        end
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        for (int c = 0; c < 6; c++) step();
        for (int k = 0; k < 16; k++) check_eq($sformatf("mem%0d", k), mem[k], m_mem[k]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
